// File: rtl/riscv_memaccess.sv
// ----------------------------------------------------------------------------
// riscv_memaccess -- memory-access (M) stage of the pipelined RV32I core.
//
// Registers the execute-stage bundle, runs loads and stores against a
// variable-latency data-memory port (req/gnt/rvalid), lane-aligns store data
// and byte enables, and sign/zero-extends load data. The registered bundle is
// handed to the writeback stage. A memory op holds the E stage (o_stallE) from
// the cycle after capture until its handshake completes. Writeback sees the
// instruction (reg write qualified) in the cycle after completion.
//
// Optional feature macro: RISCV_MEM_MISALIGN_EXC_EN
//   defined   : misaligned LH/LHU/LW/SH/SW issue no request and pulse
//               o_misalign_excM for one cycle with no rd write and no stall.
//   undefined : address bits below the access size are ignored and the
//               access is issued word-aligned.
//
// Ports
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_*E                     execute-stage bundle (valid, controls, data, rd)
//   o_stallE                 hold E and earlier stages
//   o_dmem_*, i_dmem_*       data-memory request/response handshake
//   o_*M                     registered M-stage bundle for writeback
//   o_misalign_excM          misaligned-access pulse (feature build only)
// ----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module riscv_memaccess (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_validE,
    input  logic               i_ctrl_reg_wr_enE,
    input  logic [1:0]         i_ctrl_result_srcE,
    input  logic               i_ctrl_mem_wr_enE,
    input  logic [2:0]         i_funct3E,
    input  logic [`XLEN-1:0]   i_alu_resultE,
    input  logic [`XLEN-1:0]   i_store_dataE,
    input  logic [`XLEN-1:0]   i_PCPlus4E,
    input  logic [`XLEN-1:0]   i_PCTargetE,
    input  logic [4:0]         i_regfile_rd_addrE,
    output logic               o_stallE,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [`XLEN-1:0]   o_dmem_addr,
    output logic [`XLEN-1:0]   o_dmem_wdata,
    output logic [3:0]         o_dmem_be,
    input  logic               i_dmem_gnt,
    input  logic               i_dmem_rvalid,
    input  logic [`XLEN-1:0]   i_dmem_rdata,
`ifdef RISCV_MEM_MISALIGN_EXC_EN
    output logic               o_misalign_excM,
`endif
    output logic               o_ctrl_reg_wr_enM,
    output logic [1:0]         o_ctrl_result_srcM,
    output logic [`XLEN-1:0]   o_alu_resultM,
    output logic [`XLEN-1:0]   o_mem_readdataM,
    output logic [`XLEN-1:0]   o_PCPlus4M,
    output logic [`XLEN-1:0]   o_PCTargetM,
    output logic [4:0]         o_regfile_rd_addrM,
    output logic [`XLEN-1:0]   o_writeback_dataM
);

    localparam int XLEN = `XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              reg_wr_en_q, reg_wr_en_d;
    logic [1:0]        result_src_q, result_src_d;
    logic              is_load_q, is_load_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic [XLEN-1:0]   store_data_q, store_data_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic [XLEN-1:0]   pct_q, pct_d;
    logic [4:0]        rd_q, rd_d;
    logic              done_q, done_d;        // memory op of the held instruction has completed
    logic [XLEN-1:0]   load_data_q, load_data_d;
`ifdef RISCV_MEM_MISALIGN_EXC_EN
    logic              misalign_q, misalign_d;
`endif

    logic              is_load_e, is_store_e, exc_e;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   load_ext;

    // ------------------------------------------------------------------
    // E-side decode. A bubble never loads, stores or writes rd.
    // ------------------------------------------------------------------
    always_comb begin
        is_load_e  = i_validE && !i_ctrl_mem_wr_enE && (i_ctrl_result_srcE == 2'b01);
        is_store_e = i_validE && i_ctrl_mem_wr_enE;
`ifdef RISCV_MEM_MISALIGN_EXC_EN
        exc_e = (is_load_e || is_store_e) &&
                (((i_funct3E[1:0] == 2'b01) && i_alu_resultE[0]) ||
                 ((i_funct3E[1:0] == 2'b10) && (i_alu_resultE[1:0] != 2'b00)));
`else
        exc_e = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Load lane select and extension from the raw response word.
    // ------------------------------------------------------------------
    always_comb begin
        case (alu_q[1:0])
            2'b00:   ld_byte = i_dmem_rdata[7:0];
            2'b01:   ld_byte = i_dmem_rdata[15:8];
            2'b10:   ld_byte = i_dmem_rdata[23:16];
            default: ld_byte = i_dmem_rdata[31:24];
        endcase
        ld_half = alu_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{(XLEN-8){ld_byte[7] & ~funct3_q[2]}}, ld_byte};
            2'b01:   load_ext = {{(XLEN-16){ld_half[15] & ~funct3_q[2]}}, ld_half};
            default: load_ext = i_dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: E->M capture in IDLE, handshake tracking in REQ/WAIT.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d      = state_q;
        reg_wr_en_d  = reg_wr_en_q;
        result_src_d = result_src_q;
        is_load_d    = is_load_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        alu_d        = alu_q;
        store_data_d = store_data_q;
        pc4_d        = pc4_q;
        pct_d        = pct_q;
        rd_d         = rd_q;
        done_d       = done_q;
        load_data_d  = load_data_q;
`ifdef RISCV_MEM_MISALIGN_EXC_EN
        misalign_d   = misalign_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Not stalled: take the next E instruction every cycle.
                reg_wr_en_d  = i_validE && i_ctrl_reg_wr_enE && !exc_e;
                result_src_d = i_ctrl_result_srcE;
                is_load_d    = is_load_e && !exc_e;
                is_store_d   = is_store_e && !exc_e;
                funct3_d     = i_funct3E;
                alu_d        = i_alu_resultE;
                store_data_d = i_store_dataE;
                pc4_d        = i_PCPlus4E;
                pct_d        = i_PCTargetE;
                rd_d         = i_regfile_rd_addrE;
                done_d       = 1'b0;
`ifdef RISCV_MEM_MISALIGN_EXC_EN
                misalign_d   = exc_e;
`endif
                if ((is_load_e || is_store_e) && !exc_e) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_dmem_gnt) begin
                    if (is_store_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (i_dmem_rvalid) begin
                        // Response in the grant cycle: skip WAIT.
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        load_data_d = load_ext;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (i_dmem_rvalid) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    load_data_d = load_ext;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            reg_wr_en_q  <= 1'b0;
            result_src_q <= 2'b00;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            alu_q        <= '0;
            store_data_q <= '0;
            pc4_q        <= '0;
            pct_q        <= '0;
            rd_q         <= 5'd0;
            done_q       <= 1'b0;
            load_data_q  <= '0;
`ifdef RISCV_MEM_MISALIGN_EXC_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            reg_wr_en_q  <= reg_wr_en_d;
            result_src_q <= result_src_d;
            is_load_q    <= is_load_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            alu_q        <= alu_d;
            store_data_q <= store_data_d;
            pc4_q        <= pc4_d;
            pct_q        <= pct_d;
            rd_q         <= rd_d;
            done_q       <= done_d;
            load_data_q  <= load_data_d;
`ifdef RISCV_MEM_MISALIGN_EXC_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Request fields come straight from the M register, so they
    // stay stable for as long as REQ waits for a grant.
    // ------------------------------------------------------------------
    always_comb begin
        o_stallE     = (state_q != S_IDLE);
        o_dmem_req   = (state_q == S_REQ);
        o_dmem_we    = is_store_q;
        o_dmem_addr  = {alu_q[XLEN-1:2], 2'b00};
        case (funct3_q[1:0])
            2'b00: begin
                o_dmem_be    = 4'b0001 << alu_q[1:0];
                o_dmem_wdata = {(XLEN/8){store_data_q[7:0]}};
            end
            2'b01: begin
                o_dmem_be    = alu_q[1] ? 4'b1100 : 4'b0011;
                o_dmem_wdata = {(XLEN/16){store_data_q[15:0]}};
            end
            default: begin
                o_dmem_be    = 4'b1111;
                o_dmem_wdata = store_data_q;
            end
        endcase

        // A pending memory op looks like a bubble to writeback.
        o_ctrl_reg_wr_enM  = reg_wr_en_q && (state_q == S_IDLE) &&
                             (!(is_load_q || is_store_q) || done_q);
        o_ctrl_result_srcM = (is_load_q && done_q) ? 2'b01 : 2'b00;
        o_alu_resultM      = alu_q;
        o_mem_readdataM    = load_data_q;
        o_PCPlus4M         = pc4_q;
        o_PCTargetM        = pct_q;
        o_regfile_rd_addrM = rd_q;
        case (result_src_q)
            2'b10:   o_writeback_dataM = pc4_q;
            2'b11:   o_writeback_dataM = pct_q;
            default: o_writeback_dataM = alu_q;
        endcase
`ifdef RISCV_MEM_MISALIGN_EXC_EN
        o_misalign_excM    = misalign_q;
`endif
    end

endmodule

// File: doc/riscv_memaccess.md
Name: riscv_memaccess

Overview:
- Memory-access (M) stage of the pipelined RV32I core, directly upstream of the writeback stage.
- Registers execute-stage results and runs loads/stores against a variable-latency data-memory port with a req/gnt/rvalid handshake.
- Aligns store data and byte-enables, and sign- or zero-extends load data.
- Presents the M-stage bundle the writeback stage registers: reg write enable, result select, ALU result, load data, PC+4, PC target, rd address, pre-selected non-load writeback data.

Parameters:
XLEN, 32, datapath width; taken from `XLEN in riscv_configs.v, not overridable per instance.

Ports:
i_clk  input  1  stage clock
i_rst  input  1  asynchronous, active-high reset
i_validE  input  1  E-stage instruction valid (0 = bubble)
i_ctrl_reg_wr_enE  input  1  instruction writes rd
i_ctrl_result_srcE  input  2  00 ALU, 01 load, 10 PC+4, 11 PC target
i_ctrl_mem_wr_enE  input  1  store
i_funct3E  input  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
i_alu_resultE  input  XLEN  effective address / ALU result
i_store_dataE  input  XLEN  rs2 value
i_PCPlus4E  input  XLEN  PC+4
i_PCTargetE  input  XLEN  branch/jump target
i_regfile_rd_addrE  input  5  destination register
o_stallE  output  1  hold E and earlier stages
o_dmem_req  output  1  memory request valid
o_dmem_we  output  1  1 write, 0 read
o_dmem_addr  output  XLEN  word-aligned address ({addr[31:2],2'b00})
o_dmem_wdata  output  XLEN  lane-shifted store data
o_dmem_be  output  4  byte enables
i_dmem_gnt  input  1  request accepted
i_dmem_rvalid  input  1  read data valid
i_dmem_rdata  input  XLEN  read data word
o_ctrl_reg_wr_enM  output  1  qualified rd write
o_ctrl_result_srcM  output  2  01 for a completed load, 00 otherwise
o_alu_resultM  output  XLEN  registered ALU result
o_mem_readdataM  output  XLEN  extended load data
o_PCPlus4M  output  XLEN  registered PC+4
o_PCTargetM  output  XLEN  registered PC target
o_regfile_rd_addrM  output  5  registered rd
o_writeback_dataM  output  XLEN  ALU result, PC+4 or PC target per result_src (for a load: ALU result)

Behaviour:
- Reset (i_rst high, async): every registered output is 0, FSM is IDLE, o_stallE=0, o_dmem_req=0.
- E->M register: captures all E inputs on each rising edge while o_stallE=0. While o_stallE=1 it holds.
- Non-memory instruction: 1-cycle latency. Outputs are valid the cycle after capture and o_stallE stays 0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when the captured instruction is a valid load/store. o_stallE=1 from that cycle.
  - REQ: o_dmem_req=1, with address, we, be and wdata held stable until i_dmem_gnt.
  - REQ -> IDLE on gnt for a store (stall released in the same cycle).
  - REQ -> WAIT on gnt for a load.
  - WAIT: o_dmem_req=0. On i_dmem_rvalid, latch the extended data, go to IDLE and release the stall.
  - gnt and rvalid in the same cycle in REQ: the load completes directly; WAIT is skipped.
- Output qualification: while a memory op is pending, o_ctrl_reg_wr_enM=0 (writeback sees a bubble). In the completion cycle o_ctrl_reg_wr_enM=captured reg_wr_en, and for loads o_ctrl_result_srcM=01.
- Stores: SB replicates byte 0 to all lanes with be=1<<addr[1:0]. SH replicates the low half with be=0011 or 1100 by addr[1]. SW uses be=1111.
- Loads: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned accesses (halfword with addr[0]=1, word with addr[1:0]!=0) are handled per the optional feature.
- Bubbles (i_validE=0): reg_wr_en and mem_wr_en are captured as 0.
- Reset mid-transaction: the FSM returns to IDLE immediately, req drops, and late gnt/rvalid are ignored.
- rvalid outside WAIT/REQ is ignored.

Optional Feature:
RISCV_MEM_MISALIGN_EXC_EN
- Defined: adds output o_misalign_excM (1 bit, reset 0). A misaligned access issues no request and raises o_misalign_excM for 1 cycle with o_ctrl_reg_wr_enM=0 and no stall.
- Undefined: the port is absent, address bits [1:0] are ignored for lane selection beyond the access size, and the access is issued word-aligned.

Test Plan:
1. ADD result 0x0000_0010, rd=5, result_src=00 -> next cycle o_ctrl_reg_wr_enM=1, o_regfile_rd_addrM=5, o_writeback_dataM=0x10, no dmem_req.
2. SB addr 0x103, rs2=0x1234_56AB, gnt after 2 cycles -> dmem_addr=0x100, be=1000, wdata=0xABAB_ABAB held 2 cycles, o_stallE high for 3 cycles, o_ctrl_reg_wr_enM=0.
3. LB addr 0x202, rdata 0x0080_0000, gnt then rvalid 3 cycles later -> o_mem_readdataM=0xFFFF_FF80, result_src=01, reg_wr_en pulses 1 only in the completion cycle. Repeat with LBU -> 0x0000_0080.
4. LW with gnt and rvalid in the same cycle, rdata 0xDEAD_BEEF -> completes without entering WAIT, stall 1 cycle, o_mem_readdataM=0xDEAD_BEEF.
5. Assert i_rst during WAIT, then drive rvalid -> outputs 0, FSM IDLE, rvalid ignored, no reg write.
6. With RISCV_MEM_MISALIGN_EXC_EN, LH addr 0x301 -> no dmem_req, o_misalign_excM=1 for 1 cycle, o_ctrl_reg_wr_enM=0.
